audio_in_recorder: RTL
======================

// Module: audio_in_recorder
// PURPOSE
//  Captures codec input samples into an on-chip RAM as the record-side counterpart of the ROM playback path.
//  Pops samples from Audio_Controller (audio_in_available / read_audio_in handshake).
//  Mixes left/right to one 32-bit word and writes it to a single-port RAM, same shape as the playback ROM (address/data/wren).
//  Optional level trigger delays recording until the input exceeds a threshold.
// PARAMETERS
//  ADDR_W     16            RAM address width; DEPTH = 2**ADDR_W words
//  MIX_MODE   2             0 = left, 1 = right, 2 = average (L+R)>>>1
//  TRIG_EN    0             1 = wait in ARM for |mix| >= THRESHOLD before writing
//  THRESHOLD  32'h0100_0000 trigger level (unsigned magnitude)
// PORTS
//  CLOCK_50                in   1       system clock; sole clock domain
//  reset                   in   1       synchronous, active-high
//  start                   in   1       1-cycle pulse; begins a recording
//  stop                    in   1       1-cycle pulse; ends a recording early
//  audio_in_available      in   1       Audio_Controller: sample pair valid
//  left_channel_audio_in   in   32      signed left sample
//  right_channel_audio_in  in   32      signed right sample
//  read_audio_in           out  1       pop strobe to Audio_Controller
//  mem_address             out  ADDR_W  RAM write address
//  mem_data                out  32      RAM write data
//  mem_wren                out  1       RAM write enable (1-cycle pulse per word)
//  busy                    out  1       high in ARM or CAPTURE
//  done                    out  1       high in DONE until next start or reset
//  sample_count            out  ADDR_W+1 words written in last or current recording
// BEHAVIOUR
//  Reset: state=IDLE; read_audio_in, mem_wren, busy, done = 0; mem_address, mem_data, sample_count = 0.
//   RAM contents are not cleared.
//  Handshake: read_audio_in = audio_in_available in every state (combinational). Input FIFO is always drained.
//   Data is sampled in the cycle read_audio_in = 1.
//  Mix: sign-extend both to 33 bits, add, arithmetic shift right 1, keep low 32. Modes 0/1 pass the channel through.
//  Magnitude: |x|; 32'h8000_0000 saturates to 32'h7FFF_FFFF.
//  States:
//   IDLE:    popped samples discarded. start -> ARM if TRIG_EN, else CAPTURE. sample_count <= 0, write pointer <= 0.
//   ARM:     popped samples discarded while |mix| < THRESHOLD. The first sample with |mix| >= THRESHOLD is written at address 0, then -> CAPTURE.
//            stop -> DONE with count 0.
//   CAPTURE: every popped sample is written at the pointer. Pointer and sample_count increment.
//            After word DEPTH-1 is written -> DONE. The pointer does not wrap into a second pass.
//            stop -> DONE.
//   DONE:    done = 1; samples discarded. start -> same as from IDLE; done drops the next cycle.
//  Latency: mem_wren, mem_address, mem_data are registered and assert exactly 1 cycle after the pop cycle. mem_wren is 0 otherwise.
//  Simultaneous events:
//   - stop in the same cycle as a pop in CAPTURE: the sample is still written, then DONE.
//   - start while busy: ignored.
//   - start and stop together in IDLE/DONE: start wins.
//   - stop in IDLE/DONE: ignored.
//  busy drops and done rises in the same cycle the last mem_wren is asserted.
//  Reset mid-capture: immediate return to reset values. A pending write is dropped.
// TESTING
//  1 Reset then idle: available pulses 5x -> read_audio_in mirrors available, mem_wren never 1, done=0.
//  2 MIX_MODE=2, ADDR_W=3, L=32'h0000_0004, R=32'hFFFF_FFFE per pop, start -> 8 writes of 32'h1 at addr 0..7, each 1 cycle after its pop.
//    Then done=1, sample_count=8, and a 9th pop is not written.
//  3 MIX_MODE=2, L=R=32'h8000_0000 -> mem_data=32'h8000_0000. L=R=32'h7FFF_FFFF -> 32'h7FFF_FFFF (no overflow).
//  4 TRIG_EN=1, MIX_MODE=0, inputs 32'h10, 32'hFF00_0000, 32'h5 -> first write is 32'hFF00_0000 at addr 0; 32'h5 at addr 1; 32'h10 never written.
//  5 stop coincident with 3rd pop in CAPTURE -> 3 words written, sample_count=3, done=1 in the cycle of the 3rd mem_wren.
//  6 reset asserted mid-CAPTURE after 2 pops -> next cycle all outputs 0, state IDLE, no further mem_wren. A following start records from addr 0.

Source files
------------

// File: rtl/audio_in_recorder.sv
// Record-side counterpart of the ROM playback path: pops codec sample pairs, mixes them
// to one 32-bit word and writes it to a single-port RAM, with an optional level trigger.
module audio_in_recorder #(
    parameter int          ADDR_W    = 16,
    parameter int          MIX_MODE  = 2,
    parameter bit          TRIG_EN   = 1'b0,
    parameter logic [31:0] THRESHOLD = 32'h0100_0000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              audio_in_available,
    input  logic [31:0]       left_channel_audio_in,
    input  logic [31:0]       right_channel_audio_in,
    output logic              read_audio_in,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data,
    output logic              mem_wren,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   sample_count
);

    localparam int DATA_W = 32;
    localparam int CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

    function automatic logic signed [DATA_W-1:0] mix(input logic signed [DATA_W-1:0] l,
                                                     input logic signed [DATA_W-1:0] r);
        logic signed [DATA_W:0] sum;
        sum = {l[DATA_W-1], l} + {r[DATA_W-1], r};
        case (MIX_MODE)
            0:       return l;
            1:       return r;
            default: return sum[DATA_W:1];
        endcase
    endfunction

    // The most negative value has no positive twin, so it saturates.
    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] x);
        if (x == {1'b1, {(DATA_W-1){1'b0}}})
            return {1'b0, {(DATA_W-1){1'b1}}};
        else if (x < 0)
            return $unsigned(-x);
        else
            return $unsigned(x);
    endfunction

    state_t                    state;
    logic [ADDR_W-1:0]         ptr;
    logic [CNT_W-1:0]          count;
    logic                      wren_p1;
    logic [ADDR_W-1:0]         addr_p1;
    logic signed [DATA_W-1:0]  data_p1;
    logic                      busy_r;
    logic                      done_r;

    logic                      pop;
    logic signed [DATA_W-1:0]  mix_p0;
    logic                      trig_p0;

    // Stage p0: the FIFO is always drained; mix and trigger decode in the pop cycle.
    assign pop           = audio_in_available;
    assign read_audio_in = audio_in_available;
    assign mix_p0        = mix(left_channel_audio_in, right_channel_audio_in);
    assign trig_p0       = magnitude(mix_p0) >= THRESHOLD;

    // Stage p1: registered RAM write and control state.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            count   <= '0;
            wren_p1 <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            wren_p1 <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= TRIG_EN ? ARM : CAPTURE;
                        ptr    <= '0;
                        count  <= '0;
                        busy_r <= 1'b1;
                        done_r <= 1'b0;
                    end
                end
                ARM: begin
                    if (pop && trig_p0) begin
                        wren_p1 <= 1'b1;
                        addr_p1 <= ptr;
                        data_p1 <= mix_p0;
                        ptr     <= ptr + ADDR_W'(1);
                        count   <= count + CNT_W'(1);
                        if (stop) begin
                            state  <= DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end else begin
                            state <= CAPTURE;
                        end
                    end else if (stop) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (pop) begin
                        wren_p1 <= 1'b1;
                        addr_p1 <= ptr;
                        data_p1 <= mix_p0;
                        ptr     <= ptr + ADDR_W'(1);
                        count   <= count + CNT_W'(1);
                        // The last word ends the recording; the pointer never wraps.
                        if (stop || ptr == {ADDR_W{1'b1}}) begin
                            state  <= DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end else if (stop) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_wren     = wren_p1;
    assign mem_address  = addr_p1;
    assign mem_data     = data_p1;
    assign busy         = busy_r;
    assign done         = done_r;
    assign sample_count = count;

endmodule
